// File: rtl/regfile_issue.sv
// regfile_issue: operand-fetch/issue stage with an 8x16 register file feeding a 16-bit ALU.
// Define REGFILE_BYPASS_EN to forward alu_res to dependent issues; otherwise hazards interlock.
module regfile_issue #(
    parameter int NREGS = 8,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [2:0]   in_rd,
    input  logic [2:0]   in_rs1,
    input  logic [2:0]   in_rs2,
    input  logic         in_use_imm,
    input  logic [W-1:0] in_imm,
    input  logic         ex_stall,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_res,
    output logic         ex_valid,
    output logic [15:0]  retired_cnt
);
    localparam logic [2:0] OP_NOP = 3'd7;
    logic [W-1:0] rf [NREGS];
    logic [2:0]   ex_rd;
    logic         ex_writes, hit1, hit2, fire;
    logic [W-1:0] opnd_a, opnd_b;
    assign ex_writes = ex_valid && alu_op != OP_NOP && ex_rd != 3'd0;
    assign hit1 = ex_writes && ex_rd == in_rs1;
    assign hit2 = ex_writes && !in_use_imm && ex_rd == in_rs2;
`ifdef REGFILE_BYPASS_EN
    // The file write of the EX result lands on the same edge, so take it straight from the ALU.
    assign opnd_a = hit1 ? alu_res : rf[in_rs1];
    assign opnd_b = in_use_imm ? in_imm : hit2 ? alu_res : rf[in_rs2];
    assign in_ready = rst_n && !ex_stall;
`else
    assign opnd_a = rf[in_rs1];
    assign opnd_b = in_use_imm ? in_imm : rf[in_rs2];
    assign in_ready = rst_n && !ex_stall && !(hit1 || hit2);
`endif
    assign fire = in_valid && in_ready;
    // R0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            ex_rd       <= '0;
            ex_valid    <= 1'b0;
            retired_cnt <= '0;
        end else if (!ex_stall) begin
            if (ex_writes) rf[ex_rd] <= alu_res;
            if (ex_valid) retired_cnt <= retired_cnt + 16'd1;
            ex_valid <= fire;
            if (fire) begin
                alu_a  <= opnd_a;
                alu_b  <= opnd_b;
                alu_op <= in_op;
                ex_rd  <= in_rd;
            end
        end
    end
endmodule

// File: doc/regfile_issue.md
# regfile_issue

Operand-fetch and issue stage placed directly upstream of the 16-bit `alu`. It accepts one decoded instruction per cycle over a valid/ready handshake and reads operands from an 8×16 register file. It drives the ALU's `a`, `b` and `Op` inputs from a registered EX stage. It writes the ALU `res` back to the destination register at the end of EX. Bypass or interlock logic resolves back-to-back dependencies.

## Interface
- `NREGS`, 8, register count (index width 3; fixed for this revision)
- `W`, 16, datapath width (matches ALU)
- `clk` input 1: rising-edge clock
- `rst_n` input 1: synchronous, active-low reset
- `in_valid` input 1: decoded instruction present
- `in_ready` output 1: stage accepts the instruction this cycle
- `in_op` input 3: ALU opcode; 7 = NOP
- `in_rd` input 3: destination register
- `in_rs1` input 3: source for `a`
- `in_rs2` input 3: source for `b` when `in_use_imm`=0
- `in_use_imm` input 1: `b` comes from `in_imm`
- `in_imm` input 16: immediate
- `ex_stall` input 1: downstream holds EX (EX contents frozen, no writeback)
- `alu_a` output 16: ALU operand `a`
- `alu_b` output 16: ALU operand `b`
- `alu_op` output 3: ALU `Op`
- `alu_res` input 16: combinational ALU `res` for the current `alu_a`/`alu_b`/`alu_op`
- `ex_valid` output 1: EX holds a live instruction
- `retired_cnt` output 16: completed-instruction counter

## Operation
- R0 reads as 0. Writes to R0 are discarded.
- Issue fires when `in_valid && in_ready`. On the same edge, the EX register loads:
  - `alu_a` = R[rs1]
  - `alu_b` = use_imm ? imm : R[rs2]
  - `alu_op`, rd, and `ex_valid`=1
- Without a fire and with EX advancing, `ex_valid`←0. `alu_a`/`alu_b`/`alu_op` hold their last values.
- EX advances when `!ex_stall`. On an advancing edge with `ex_valid`=1:
  - if `alu_op`≠7 and rd≠0, R[rd]←`alu_res`
  - `retired_cnt`++ (wraps 0xFFFF→0x0000; NOP counts)
- `in_ready` = `!ex_stall` (bypass build), further qualified by the hazard interlock (interlock build).
- Hazard: `ex_valid` && EX op≠7 && EX rd≠0 && (EX rd==rs1 || (!use_imm && EX rd==rs2)).
- Reset (`rst_n`=0 at an edge):
  - all registers, `alu_a`, `alu_b`, `alu_op`, `ex_valid`, and `retired_cnt` go to 0
  - an in-flight EX instruction is dropped without writeback
  - `in_ready` is 0 during the reset cycle

## Timing
- Issue to operands on ALU ports: 1 cycle. Issue to register written: 2 edges with no stall.
- Throughput is 1 instruction/cycle with bypass. The interlock build inserts 1 bubble per hazard.
- Same-edge case: EX writes back R[x] while the issuing instruction reads x. With a hazard, the bypass build takes the operand from `alu_res`, not the stale file value.
- `ex_stall`=1:
  - EX frozen, no writeback, no count, `in_ready`=0
  - `alu_*` outputs stable until `ex_stall` drops
- `in_*` is sampled only on a fire edge; the producer holds it while `in_ready`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - the hazard operand is muxed from `alu_res`
  - `in_ready` ignores hazards
- Undefined:
  - no forwarding path
  - `in_ready` = `!ex_stall && !hazard`; the dependent instruction issues the cycle after writeback

## Test plan
Bench instantiates the real `alu` (Op 0 = add) between `alu_*` and `alu_res`.
- Reset: hold `rst_n`=0 for 2 cycles -> all outputs 0, `in_ready`=0, `ex_valid`=0.
- Load then add:
  - issue op0 rd1 rs1=0 imm=0x006A
  - issue op0 rd2 rs1=0 imm=0x003B
  - issue op0 rd3 rs1=1 rs2=2
  - -> R3=0x00A5 and `retired_cnt`=3
- Back-to-back dependency: op0 rd1 r0+0x006A, then op0 rd4 rs1=1 imm=0x003B.
  - bypass build: `alu_a`=0x006A on the next cycle, no bubble, R4=0x00A5
  - non-bypass build: `in_ready`=0 for exactly 1 cycle, same final result
- R0 and NOP:
  - op0 rd0 imm=0x1234 -> R0 still reads 0
  - op7 rd5 -> R5 unchanged
  - both increment `retired_cnt`
- Stall: assert `ex_stall` for 3 cycles with EX live -> `alu_*` stable, `in_ready`=0, no writeback; writeback occurs on the first edge after release.
- Reset mid-operation: `rst_n`=0 while EX holds op0 rd6 -> R6=0, `ex_valid`=0. Also preload `retired_cnt`=0xFFFF and retire one more -> reads 0x0000.
